// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access and writeback stage of a three-stage pipeline
// Ports: clk, reset (async active-low); pc_in/alu_out_in/rs2d_in/jump_in/inst_in from the X stage;
// dcache_addr/din/we/re out, dcache_dout/dcache_stall in; stall, wb_en/wb_rd/wb_data, misalign_err out.
// Define MISALIGN_CHECK_EN to trap misaligned half/word accesses instead of truncating the offset.
module mem_wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_out_in,
  input  logic [31:0] rs2d_in,
  input  logic        jump_in,
  input  logic [31:0] inst_in,
  output logic [31:0] dcache_addr,
  output logic [31:0] dcache_din,
  output logic [3:0]  dcache_we,
  output logic        dcache_re,
  input  logic [31:0] dcache_dout,
  input  logic        dcache_stall,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic        is_load, is_store, is_link, is_alu, mis;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] load_aligned, load_q;
  logic [3:0]  st_mask;
  logic        unused_ok;
  assign opc      = inst_in[6:0];
  assign f3       = inst_in[14:12];
  assign off      = alu_out_in[1:0];
  assign is_load  = opc == 7'b0000011;
  assign is_store = opc == 7'b0100011;
  assign is_link  = opc == 7'b1101111 || opc == 7'b1100111;
  assign is_alu   = opc == 7'b0110111 || opc == 7'b0010111 || opc == 7'b0110011 || opc == 7'b0010011;
  assign unused_ok = ^{jump_in, inst_in[31:15]};
  assign dcache_addr = {alu_out_in[31:2], 2'b00};
  assign dcache_din  = rs2d_in << {off, 3'b000};
  assign st_mask = f3[1:0] == 2'b00 ? 4'b0001 << off : f3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
  assign ld_b = 8'(dcache_dout >> {off, 3'b000});
  assign ld_h = 16'(dcache_dout >> {off[1], 4'b0000});
  assign load_aligned = f3 == 3'b000 ? {{24{ld_b[7]}}, ld_b}
                      : f3 == 3'b100 ? {24'h0, ld_b}
                      : f3 == 3'b001 ? {{16{ld_h[15]}}, ld_h}
                      : f3 == 3'b101 ? {16'h0, ld_h} : dcache_dout;
`ifdef MISALIGN_CHECK_EN
  assign mis = (is_load || is_store) &&
               ((f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00));
  always_ff @(posedge clk or negedge reset)
    if (!reset) misalign_err <= 1'b0;
    else if (mis && state == IDLE) misalign_err <= 1'b1;
`else
  assign mis = 1'b0;
  assign misalign_err = 1'b0;
`endif
  // Control outputs are forced quiet while reset is held, even though state is already IDLE.
  always_comb begin
    state_nx  = state;
    stall     = 1'b0;
    dcache_re = 1'b0;
    dcache_we = 4'b0000;
    if (state == IDLE) begin
      if (is_load && !mis) begin
        dcache_re = 1'b1;
        stall     = 1'b1;
        state_nx  = ACCESS;
      end else if (is_store && !mis) begin
        dcache_we = st_mask;
        stall     = dcache_stall;
      end
    end else if (state == ACCESS) begin
      dcache_re = 1'b1;
      stall     = 1'b1;
      state_nx  = dcache_stall ? ACCESS : DONE;
    end else begin
      state_nx = IDLE;
    end
    if (!reset) begin
      stall     = 1'b0;
      dcache_re = 1'b0;
      dcache_we = 4'b0000;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      load_q <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == ACCESS && !dcache_stall) load_q <= load_aligned;
    end
  assign wb_rd   = inst_in[11:7];
  assign wb_en   = reset && wb_rd != 5'd0 && !mis && (is_link || is_alu || (is_load && state == DONE));
  assign wb_data = is_link ? pc_in + 32'd4 : is_load ? load_q : alu_out_in;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: vector table, directed load/store/reset sequences and randomized checks for mem_wb_stage
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, alu_out_in, rs2d_in, inst_in, dcache_dout;
  logic        jump_in, dcache_stall;
  logic [31:0] dcache_addr, dcache_din, wb_data;
  logic [3:0]  dcache_we;
  logic        dcache_re, stall, wb_en, misalign_err;
  logic [4:0]  wb_rd;
  int checks = 0;
  int errors = 0;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_OP = 7'b0110011, OP_IMM = 7'b0010011, OP_BR = 7'b1100011;
  localparam logic [31:0] NOP = 32'h00000013;
  mem_wb_stage dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .alu_out_in(alu_out_in), .rs2d_in(rs2d_in),
    .jump_in(jump_in), .inst_in(inst_in), .dcache_addr(dcache_addr), .dcache_din(dcache_din),
    .dcache_we(dcache_we), .dcache_re(dcache_re), .dcache_dout(dcache_dout),
    .dcache_stall(dcache_stall), .stall(stall), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] inst, pc, alu, rs2;
    logic        en;
    logic [31:0] data;
    logic [3:0]  we;
    logic [31:0] din;
  } vec_t;
  vec_t tbl[12];
  function automatic logic [31:0] mk(input logic [6:0] opc, input int rd, input int f3);
    mk = {17'h0, 3'(f3), 5'(rd), opc};
  endfunction
  function automatic logic [31:0] load_val(input int f3, input int off, input logic [31:0] d);
    logic [31:0] v;
    if (f3 == 0 || f3 == 4) begin
      v = (d >> (8 * off)) & 32'hFF;
      if (f3 == 0 && v >= 128) v = v - 32'd256;
    end else if (f3 == 1 || f3 == 5) begin
      v = (d >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 1 && v >= 32768) v = v - 32'd65536;
    end else v = d;
    return v;
  endfunction
  function automatic logic [3:0] store_mask(input int f3, input int off);
    int n;
    n = f3 == 0 ? 1 : f3 == 1 ? 2 : 4;
    return n == 4 ? 4'hF : 4'(((1 << n) - 1) << off);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // Drives a load and counts stall cycles; dcache_stall is high during the first n cycles of the load.
  task automatic run_load(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] dout,
                          input int n, input logic [31:0] exp_data, input logic exp_en);
    int cyc;
    bit done;
    cyc = 0;
    done = 0;
    inst_in = inst;
    alu_out_in = alu;
    dcache_dout = dout;
    while (!done && cyc < 40) begin
      dcache_stall = cyc < n;
      #3;
      if (stall) begin
        if (cyc == 0) begin
          chk("ld_re", 32'(dcache_re), 32'd1);
          chk("ld_addr", dcache_addr, alu & 32'hFFFF_FFFC);
        end
        cyc++;
        step();
      end else done = 1;
    end
    chk("ld_stall_cycles", cyc, (n + 1 > 2) ? n + 1 : 2);
    chk("ld_wb_en", 32'(wb_en), 32'(exp_en));
    if (exp_en) begin
      chk("ld_wb_rd", 32'(wb_rd), 32'(inst[11:7]));
      chk("ld_wb_data", wb_data, exp_data);
    end
    dcache_stall = 1'b0;
    step();
    inst_in = NOP;
  endtask
  initial begin
    tbl[0]  = '{mk(OP_STORE, 0, 1), 32'h0, 32'h2002, 32'h0000ABCD, 1'b0, 32'h0, 4'b1100, 32'hABCD0000};
    tbl[1]  = '{mk(OP_JAL, 1, 0), 32'hFFFFFFFC, 32'h123, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0};
    tbl[2]  = '{mk(OP_STORE, 0, 0), 32'h0, 32'h13, 32'h12345678, 1'b0, 32'h0, 4'b1000, 32'h78000000};
    tbl[3]  = '{mk(OP_STORE, 0, 2), 32'h0, 32'h40, 32'hCAFEBABE, 1'b0, 32'h0, 4'b1111, 32'hCAFEBABE};
    tbl[4]  = '{mk(OP_LUI, 7, 0), 32'h0, 32'h12345000, 32'h0, 1'b1, 32'h12345000, 4'b0000, 32'h0};
    tbl[5]  = '{mk(OP_OP, 0, 0), 32'h0, 32'h5, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0};
    tbl[6]  = '{mk(OP_BR, 3, 0), 32'h0, 32'h8, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0};
    tbl[7]  = '{mk(OP_JALR, 2, 0), 32'h100, 32'h200, 32'h0, 1'b1, 32'h104, 4'b0000, 32'h0};
    tbl[8]  = '{mk(OP_IMM, 31, 0), 32'h0, 32'hFFFF, 32'h0, 1'b1, 32'hFFFF, 4'b0000, 32'h0};
    tbl[9]  = '{mk(OP_AUIPC, 4, 0), 32'h0, 32'h80001000, 32'h0, 1'b1, 32'h80001000, 4'b0000, 32'h0};
    tbl[10] = '{mk(OP_STORE, 0, 0), 32'h0, 32'h21, 32'h000000AB, 1'b0, 32'h0, 4'b0010, 32'h0000AB00};
    tbl[11] = '{mk(7'b1111111, 9, 0), 32'h0, 32'h77, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0};
    reset = 1'b0;
    jump_in = 1'b1;
    pc_in = 32'h0;
    rs2d_in = 32'h0;
    dcache_dout = 32'h0;
    dcache_stall = 1'b0;
    alu_out_in = 32'h1000;
    inst_in = mk(OP_LOAD, 5, 2);
    #3;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_re", 32'(dcache_re), 32'd0);
    chk("rst_wb_en_load", 32'(wb_en), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    inst_in = mk(OP_STORE, 0, 2);
    #1;
    chk("rst_we", 32'(dcache_we), 32'd0);
    inst_in = mk(OP_JAL, 1, 0);
    #1;
    chk("rst_wb_en_jal", 32'(wb_en), 32'd0);
    step();
    step();
    inst_in = NOP;
    reset = 1'b1;
    step();
    foreach (tbl[i]) begin
      inst_in = tbl[i].inst;
      pc_in = tbl[i].pc;
      alu_out_in = tbl[i].alu;
      rs2d_in = tbl[i].rs2;
      jump_in = 1'(i);
      #3;
      chk($sformatf("vec%0d_wb_en", i), 32'(wb_en), 32'(tbl[i].en));
      chk($sformatf("vec%0d_we", i), 32'(dcache_we), 32'(tbl[i].we));
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'd0);
      chk($sformatf("vec%0d_re", i), 32'(dcache_re), 32'd0);
      chk($sformatf("vec%0d_addr", i), dcache_addr, {tbl[i].alu[31:2], 2'b00});
      if (tbl[i].en) begin
        chk($sformatf("vec%0d_wb_data", i), wb_data, tbl[i].data);
        chk($sformatf("vec%0d_wb_rd", i), 32'(wb_rd), 32'(tbl[i].inst[11:7]));
      end
      if (tbl[i].we != 4'b0000) chk($sformatf("vec%0d_din", i), dcache_din, tbl[i].din);
      step();
    end
    inst_in = NOP;
    step();
    run_load(mk(OP_LOAD, 5, 2), 32'h1000, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b1);
    run_load(mk(OP_LOAD, 6, 0), 32'h1003, 32'h80112233, 0, 32'hFFFFFF80, 1'b1);
    run_load(mk(OP_LOAD, 7, 4), 32'h1003, 32'h80112233, 0, 32'h00000080, 1'b1);
    run_load(mk(OP_LOAD, 8, 1), 32'h1002, 32'h9ABC1234, 0, 32'hFFFF9ABC, 1'b1);
    run_load(mk(OP_LOAD, 9, 5), 32'h1002, 32'h9ABC1234, 1, 32'h00009ABC, 1'b1);
    run_load(mk(OP_LOAD, 10, 2), 32'h1000, 32'h01020304, 3, 32'h01020304, 1'b1);
    run_load(mk(OP_LOAD, 0, 2), 32'h1000, 32'h55555555, 0, 32'h0, 1'b0);
    inst_in = mk(OP_STORE, 0, 2);
    alu_out_in = 32'h3004;
    rs2d_in = 32'h11223344;
    dcache_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #3;
      chk("st_hold_stall", 32'(stall), 32'd1);
      chk("st_hold_we", 32'(dcache_we), 32'hF);
      chk("st_hold_addr", dcache_addr, 32'h3004);
      chk("st_hold_din", dcache_din, 32'h11223344);
      step();
    end
    dcache_stall = 1'b0;
    #3;
    chk("st_release_stall", 32'(stall), 32'd0);
    step();
    inst_in = mk(OP_LOAD, 6, 2);
    alu_out_in = 32'h3000;
    dcache_dout = 32'hA5A5A5A5;
    dcache_stall = 1'b1;
    step();
    #3;
    chk("abort_in_access", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_re", 32'(dcache_re), 32'd0);
    chk("abort_wb_en", 32'(wb_en), 32'd0);
    inst_in = mk(OP_STORE, 6, 2);
    dcache_stall = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("post_abort_stall", 32'(stall), 32'd0);
      chk("post_abort_re", 32'(dcache_re), 32'd0);
      chk("post_abort_wb_en", 32'(wb_en), 32'd0);
      step();
    end
    inst_in = NOP;
    step();
`ifdef MISALIGN_CHECK_EN
    inst_in = mk(OP_LOAD, 5, 2);
    alu_out_in = 32'h1001;
    #3;
    chk("mis_re", 32'(dcache_re), 32'd0);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_wb_en", 32'(wb_en), 32'd0);
    step();
    inst_in = NOP;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("mis_sticky", 32'(misalign_err), 32'd1);
      step();
    end
    reset = 1'b0;
    #1;
    chk("mis_cleared", 32'(misalign_err), 32'd0);
    step();
    reset = 1'b1;
    step();
`else
    run_load(mk(OP_LOAD, 5, 2), 32'h1001, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b1);
    chk("mis_tied_low", 32'(misalign_err), 32'd0);
`endif
    for (int it = 0; it < 40; it++) begin
      int f3s[5] = '{0, 1, 2, 4, 5};
      int f3, sf3, rd, n;
      logic [31:0] alu, dout, rs2;
      f3 = f3s[$urandom_range(0, 4)];
      rd = $urandom_range(0, 31);
      n = $urandom_range(0, 3);
      alu = $urandom;
      dout = $urandom;
`ifdef MISALIGN_CHECK_EN
      if (f3 == 2) alu[1:0] = 2'b00;
      if (f3 == 1 || f3 == 5) alu[0] = 1'b0;
`endif
      run_load(mk(OP_LOAD, rd, f3), alu, dout, n, load_val(f3, int'(alu[1:0]), dout), rd != 0);
      sf3 = $urandom_range(0, 2);
      alu = $urandom;
      rs2 = $urandom;
`ifdef MISALIGN_CHECK_EN
      if (sf3 == 2) alu[1:0] = 2'b00;
      if (sf3 == 1) alu[0] = 1'b0;
`endif
      inst_in = mk(OP_STORE, rd, sf3);
      alu_out_in = alu;
      rs2d_in = rs2;
      #3;
      chk("rnd_st_we", 32'(dcache_we), 32'(store_mask(sf3, int'(alu[1:0]))));
      chk("rnd_st_din", dcache_din, rs2 << (8 * alu[1:0]));
      chk("rnd_st_stall", 32'(stall), 32'd0);
      chk("rnd_st_wb_en", 32'(wb_en), 32'd0);
      step();
      inst_in = NOP;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
